// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the 8-bit pipeline.
// Owns the PC and sequences one-word and two-word instructions.
// Two-word instructions are marked by an opcode upper nibble of MW_NIBBLE.
// The opcode of a two-word instruction is parked in op_hold while its second
// byte is fetched. The opcode is then published on IF/ID on the same edge on
// which the immediate register captures instr_data, so decode sees both
// bytes together.
module fetch_unit #(
    parameter logic [7:0] RESET_VEC = 8'h00,
    parameter logic [3:0] MW_NIBBLE = 4'hC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] instr_addr,
    input  logic [7:0] instr_data,
    output logic       IR_en,
    output logic [7:0] ifid_instr,
    output logic [7:0] ifid_pc,
    output logic       ifid_valid
);

    typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] op_hold, op_hold_nxt;
    logic [7:0] op_pc, op_pc_nxt;
    logic [7:0] ifid_instr_nxt, ifid_pc_nxt;
    logic       ifid_valid_nxt;
    logic       mw;

    assign instr_addr = pc;
    assign mw         = (instr_data[7:4] == MW_NIBBLE);

    // State and pipeline registers; reset discards any half-fetched opcode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_OP;
            pc         <= RESET_VEC;
            op_hold    <= 8'h00;
            op_pc      <= 8'h00;
            ifid_instr <= 8'h00;
            ifid_pc    <= 8'h00;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            op_hold    <= op_hold_nxt;
            op_pc      <= op_pc_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_valid <= ifid_valid_nxt;
        end
    end

    // Next-state and IR_en: branch beats stall, stall beats normal advance
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        op_hold_nxt    = op_hold;
        op_pc_nxt      = op_pc;
        ifid_instr_nxt = ifid_instr;
        ifid_pc_nxt    = ifid_pc;
        ifid_valid_nxt = ifid_valid;
        IR_en          = 1'b0;

        if (branch_taken) begin
            // Redirect: any half-fetched two-word instruction is dropped
            pc_nxt         = branch_target;
            state_nxt      = S_OP;
            ifid_valid_nxt = 1'b0;
        end else if (!stall) begin
            unique case (state)
                S_OP: begin
                    pc_nxt = pc + 8'h01;
                    if (mw) begin
                        // Park the opcode and insert a bubble until the immediate arrives
                        op_hold_nxt    = instr_data;
                        op_pc_nxt      = pc;
                        ifid_valid_nxt = 1'b0;
                        state_nxt      = S_IMM;
                    end else begin
                        ifid_instr_nxt = instr_data;
                        ifid_pc_nxt    = pc;
                        ifid_valid_nxt = 1'b1;
                    end
                end
                S_IMM: begin
                    // Immediate is on the bus now; issue the parked opcode alongside it
                    IR_en          = rst_n;
                    ifid_instr_nxt = op_hold;
                    ifid_pc_nxt    = op_pc;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc + 8'h01;
                    state_nxt      = S_OP;
                end
                default: state_nxt = S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit against a byte-wide memory model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n, stall, branch_taken;
    logic [7:0] branch_target, instr_addr, instr_data;
    logic       IR_en, ifid_valid;
    logic [7:0] ifid_instr, ifid_pc;
    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_VEC(8'h00), .MW_NIBBLE(4'hC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instr_addr(instr_addr), .instr_data(instr_data),
        .IR_en(IR_en), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    // Asynchronous-read instruction memory
    always_comb instr_data = mem[instr_addr];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic jump(input logic [7:0] t);
        branch_taken = 1'b1; branch_target = t;
        step();
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        clr_mem();
        mem[0] = 8'hC1;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step();
        step();
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", ifid_valid); end
        tests++; if (ifid_instr !== 8'h00) begin fails++; $display("FAIL rst_instr got %h want 00", ifid_instr); end
        tests++; if (ifid_pc !== 8'h00) begin fails++; $display("FAIL rst_pc got %h want 00", ifid_pc); end
        tests++; if (instr_addr !== 8'h00) begin fails++; $display("FAIL rst_addr got %h want 00", instr_addr); end
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL rst_iren got %b want 0", IR_en); end
        rst_n = 1'b1;
    endtask

    task automatic test_one_word();
        logic [7:0] exp_i [3];
        clr_mem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        exp_i[0] = 8'h01; exp_i[1] = 8'h02; exp_i[2] = 8'h03;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL ow_valid[%0d] got %b want 1", k, ifid_valid); end
            tests++; if (ifid_instr !== exp_i[k]) begin fails++; $display("FAIL ow_instr[%0d] got %h want %h", k, ifid_instr, exp_i[k]); end
            tests++; if (ifid_pc !== 8'(k)) begin fails++; $display("FAIL ow_pc[%0d] got %h want %h", k, ifid_pc, 8'(k)); end
            tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL ow_iren[%0d] got %b want 0", k, IR_en); end
        end
        // Stall in S_OP freezes address and IF/ID
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            tests++; if (instr_addr !== 8'h03) begin fails++; $display("FAIL sop_addr got %h want 03", instr_addr); end
            tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h03, 8'h02})
                begin fails++; $display("FAIL sop_ifid got %b/%h/%h want 1/03/02", ifid_valid, ifid_instr, ifid_pc); end
        end
        stall = 1'b0;
    endtask

    task automatic test_two_word();
        clr_mem();
        mem[0] = 8'hC1; mem[1] = 8'h42; mem[2] = 8'h05;
        do_reset();
        step();
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL tw_bubble got %b want 0", ifid_valid); end
        tests++; if (IR_en !== 1'b1) begin fails++; $display("FAIL tw_iren got %b want 1", IR_en); end
        tests++; if (instr_data !== 8'h42) begin fails++; $display("FAIL tw_imm got %h want 42", instr_data); end
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'hC1, 8'h00})
            begin fails++; $display("FAIL tw_issue got %b/%h/%h want 1/c1/00", ifid_valid, ifid_instr, ifid_pc); end
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL tw_iren_off got %b want 0", IR_en); end
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h05, 8'h02})
            begin fails++; $display("FAIL tw_next got %b/%h/%h want 1/05/02", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_stall_imm();
        clr_mem();
        mem[8'h10] = 8'hC5; mem[8'h11] = 8'h77;
        do_reset();
        jump(8'h10);
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL st_iren[%0d] got %b want 0", k, IR_en); end
            tests++; if (instr_addr !== 8'h11) begin fails++; $display("FAIL st_addr[%0d] got %h want 11", k, instr_addr); end
            tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL st_valid[%0d] got %b want 0", k, ifid_valid); end
            step();
        end
        stall = 1'b0;
        #1;
        tests++; if (IR_en !== 1'b1) begin fails++; $display("FAIL st_release_iren got %b want 1", IR_en); end
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'hC5, 8'h10})
            begin fails++; $display("FAIL st_issue got %b/%h/%h want 1/c5/10", ifid_valid, ifid_instr, ifid_pc); end
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL st_iren_after got %b want 0", IR_en); end
    endtask

    task automatic test_branch_stall();
        clr_mem();
        mem[8'h20] = 8'hC3; mem[8'h21] = 8'h99; mem[8'h40] = 8'h07;
        do_reset();
        jump(8'h20);
        step();
        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1;
        #1;
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL br_iren got %b want 0", IR_en); end
        step();
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        tests++; if (instr_addr !== 8'h40) begin fails++; $display("FAIL br_addr got %h want 40", instr_addr); end
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL br_valid got %b want 0", ifid_valid); end
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL br_state got IR_en %b want 0", IR_en); end
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h07, 8'h40})
            begin fails++; $display("FAIL br_fetch got %b/%h/%h want 1/07/40", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_wrap();
        clr_mem();
        mem[8'hFF] = 8'hCA; mem[8'h00] = 8'h90; mem[8'h01] = 8'h11;
        do_reset();
        jump(8'hFF);
        tests++; if (instr_addr !== 8'hFF) begin fails++; $display("FAIL wr_addr0 got %h want ff", instr_addr); end
        step();
        tests++; if (instr_addr !== 8'h00) begin fails++; $display("FAIL wr_addr1 got %h want 00", instr_addr); end
        tests++; if (IR_en !== 1'b1) begin fails++; $display("FAIL wr_iren got %b want 1", IR_en); end
        step();
        tests++; if (instr_addr !== 8'h01) begin fails++; $display("FAIL wr_addr2 got %h want 01", instr_addr); end
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'hCA, 8'hFF})
            begin fails++; $display("FAIL wr_issue got %b/%h/%h want 1/ca/ff", ifid_valid, ifid_instr, ifid_pc); end
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h11, 8'h01})
            begin fails++; $display("FAIL wr_next got %b/%h/%h want 1/11/01", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    task automatic test_reset_mid_imm();
        clr_mem();
        mem[0] = 8'hC1; mem[1] = 8'h55;
        do_reset();
        step();
        rst_n = 1'b0;
        #1;
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL rm_iren got %b want 0", IR_en); end
        step();
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got %b want 0", ifid_valid); end
        tests++; if (instr_addr !== 8'h00) begin fails++; $display("FAIL rm_addr got %h want 00", instr_addr); end
        tests++; if (IR_en !== 1'b0) begin fails++; $display("FAIL rm_iren2 got %b want 0", IR_en); end
        mem[0] = 8'h03;
        rst_n = 1'b1;
        step();
        tests++; if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b1, 8'h03, 8'h00})
            begin fails++; $display("FAIL rm_after got %b/%h/%h want 1/03/00", ifid_valid, ifid_instr, ifid_pc); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        clr_mem();
        test_reset();
        test_one_word();
        test_two_word();
        test_stall_imm();
        test_branch_stall();
        test_wrap();
        test_reset_mid_imm();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
